c7bbiu: RTL and testbench

Bus interface unit sitting directly below the core. It arbitrates the IFU read port, the LSU read port and the LSU write port onto a single 64-bit external memory port. It supports one outstanding transaction at a time. Address, write data and strobe are captured at grant, and read data and write completion are returned to the owning requestor.

---
 rtl/c7bbiu.sv | 153 +++++++++++++++
 tb/tb_c7bbiu.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c7bbiu.sv
// Bus interface unit: arbitrates IFU read, LSU read and LSU write onto a
// single 64-bit external memory port with one transaction in flight.
module c7bbiu #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ifu_biu_rd_req,
    input  logic [ADDR_W-1:0] ifu_biu_rd_addr,
    output logic              biu_ifu_rd_ack,
    output logic              biu_ifu_data_valid,
    output logic [63:0]       biu_ifu_data,
    input  logic              lsu_biu_rd_req,
    input  logic [ADDR_W-1:0] lsu_biu_rd_addr,
    output logic              biu_lsu_rd_ack,
    output logic              biu_lsu_data_valid,
    output logic [63:0]       biu_lsu_data,
    input  logic              lsu_biu_wr_req,
    input  logic [ADDR_W-1:0] lsu_biu_wr_addr,
    input  logic [63:0]       lsu_biu_wr_data,
    input  logic [7:0]        lsu_biu_wr_strb,
    output logic              biu_lsu_wr_ack,
    output logic              biu_lsu_write_done,
    output logic              biu_mem_req,
    output logic              biu_mem_we,
    output logic [ADDR_W-1:0] biu_mem_addr,
    output logic [63:0]       biu_mem_wdata,
    output logic [7:0]        biu_mem_wstrb,
    input  logic              mem_biu_gnt,
    input  logic              mem_biu_rvalid,
    input  logic [63:0]       mem_biu_rdata,
    input  logic              mem_biu_bvalid
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WAIT_W} state_t;
    typedef enum logic [1:0] {OWN_IFU, OWN_LSU_RD, OWN_LSU_WR} owner_t;

    state_t           state;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;

    logic             ifu_force;
    logic             pick_wr;
    logic             pick_rd;
    logic             pick_ifu;
    logic [CNT_W-1:0] cnt_lsu;

    // Counter value to load when the LSU wins this arbitration round
    always_comb begin
        ifu_force = ifu_biu_rd_req && (starve_cnt == CNT_MAX);
        pick_wr   = lsu_biu_wr_req && !ifu_force;
        pick_rd   = lsu_biu_rd_req && !lsu_biu_wr_req && !ifu_force;
        pick_ifu  = ifu_biu_rd_req && !pick_wr && !pick_rd;
        cnt_lsu   = '0;
        if (ifu_biu_rd_req) begin
            cnt_lsu = (starve_cnt == CNT_MAX) ? starve_cnt
                                              : starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state              <= IDLE;
            owner              <= OWN_IFU;
            starve_cnt         <= '0;
            biu_ifu_rd_ack     <= 1'b0;
            biu_ifu_data_valid <= 1'b0;
            biu_ifu_data       <= '0;
            biu_lsu_rd_ack     <= 1'b0;
            biu_lsu_data_valid <= 1'b0;
            biu_lsu_data       <= '0;
            biu_lsu_wr_ack     <= 1'b0;
            biu_lsu_write_done <= 1'b0;
            biu_mem_req        <= 1'b0;
            biu_mem_we         <= 1'b0;
            biu_mem_addr       <= '0;
            biu_mem_wdata      <= '0;
            biu_mem_wstrb      <= '0;
        end else begin
            biu_ifu_rd_ack     <= 1'b0;
            biu_lsu_rd_ack     <= 1'b0;
            biu_lsu_wr_ack     <= 1'b0;
            biu_ifu_data_valid <= 1'b0;
            biu_lsu_data_valid <= 1'b0;
            biu_lsu_write_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_wr) begin
                        owner          <= OWN_LSU_WR;
                        starve_cnt     <= cnt_lsu;
                        biu_lsu_wr_ack <= 1'b1;
                        biu_mem_req    <= 1'b1;
                        biu_mem_we     <= 1'b1;
                        biu_mem_addr   <= lsu_biu_wr_addr;
                        biu_mem_wdata  <= lsu_biu_wr_data;
                        biu_mem_wstrb  <= lsu_biu_wr_strb;
                        state          <= REQ;
                    end else if (pick_rd) begin
                        owner          <= OWN_LSU_RD;
                        starve_cnt     <= cnt_lsu;
                        biu_lsu_rd_ack <= 1'b1;
                        biu_mem_req    <= 1'b1;
                        biu_mem_we     <= 1'b0;
                        biu_mem_addr   <= lsu_biu_rd_addr;
                        biu_mem_wdata  <= '0;
                        biu_mem_wstrb  <= '0;
                        state          <= REQ;
                    end else if (pick_ifu) begin
                        owner          <= OWN_IFU;
                        starve_cnt     <= '0;
                        biu_ifu_rd_ack <= 1'b1;
                        biu_mem_req    <= 1'b1;
                        biu_mem_we     <= 1'b0;
                        biu_mem_addr   <= ifu_biu_rd_addr;
                        biu_mem_wdata  <= '0;
                        biu_mem_wstrb  <= '0;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (mem_biu_gnt) begin
                        biu_mem_req <= 1'b0;
                        state       <= biu_mem_we ? WAIT_W : WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (mem_biu_rvalid) begin
                        if (owner == OWN_IFU) begin
                            biu_ifu_data       <= mem_biu_rdata;
                            biu_ifu_data_valid <= 1'b1;
                        end else begin
                            biu_lsu_data       <= mem_biu_rdata;
                            biu_lsu_data_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                WAIT_W: begin
                    if (mem_biu_bvalid) begin
                        biu_lsu_write_done <= 1'b1;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c7bbiu.sv
// Directed bench for c7bbiu: table of single transactions plus
// hand-written arbitration, starvation, back-to-back and reset sequences.
module tb_c7bbiu;

    localparam logic [1:0] K_IFU = 2'd0;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_WR  = 2'd2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ifu_biu_rd_req;
    logic [31:0] ifu_biu_rd_addr;
    logic        biu_ifu_rd_ack;
    logic        biu_ifu_data_valid;
    logic [63:0] biu_ifu_data;
    logic        lsu_biu_rd_req;
    logic [31:0] lsu_biu_rd_addr;
    logic        biu_lsu_rd_ack;
    logic        biu_lsu_data_valid;
    logic [63:0] biu_lsu_data;
    logic        lsu_biu_wr_req;
    logic [31:0] lsu_biu_wr_addr;
    logic [63:0] lsu_biu_wr_data;
    logic [7:0]  lsu_biu_wr_strb;
    logic        biu_lsu_wr_ack;
    logic        biu_lsu_write_done;
    logic        biu_mem_req;
    logic        biu_mem_we;
    logic [31:0] biu_mem_addr;
    logic [63:0] biu_mem_wdata;
    logic [7:0]  biu_mem_wstrb;
    logic        mem_biu_gnt;
    logic        mem_biu_rvalid;
    logic [63:0] mem_biu_rdata;
    logic        mem_biu_bvalid;

    c7bbiu #(.STARVE_MAX(4), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .ifu_biu_rd_req(ifu_biu_rd_req), .ifu_biu_rd_addr(ifu_biu_rd_addr),
        .biu_ifu_rd_ack(biu_ifu_rd_ack),
        .biu_ifu_data_valid(biu_ifu_data_valid), .biu_ifu_data(biu_ifu_data),
        .lsu_biu_rd_req(lsu_biu_rd_req), .lsu_biu_rd_addr(lsu_biu_rd_addr),
        .biu_lsu_rd_ack(biu_lsu_rd_ack),
        .biu_lsu_data_valid(biu_lsu_data_valid), .biu_lsu_data(biu_lsu_data),
        .lsu_biu_wr_req(lsu_biu_wr_req), .lsu_biu_wr_addr(lsu_biu_wr_addr),
        .lsu_biu_wr_data(lsu_biu_wr_data), .lsu_biu_wr_strb(lsu_biu_wr_strb),
        .biu_lsu_wr_ack(biu_lsu_wr_ack),
        .biu_lsu_write_done(biu_lsu_write_done),
        .biu_mem_req(biu_mem_req), .biu_mem_we(biu_mem_we),
        .biu_mem_addr(biu_mem_addr), .biu_mem_wdata(biu_mem_wdata),
        .biu_mem_wstrb(biu_mem_wstrb),
        .mem_biu_gnt(mem_biu_gnt), .mem_biu_rvalid(mem_biu_rvalid),
        .mem_biu_rdata(mem_biu_rdata), .mem_biu_bvalid(mem_biu_bvalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        int          gnt_wait;
        int          resp_wait;
        logic [63:0] rdata;
        logic        exp_we;
        logic [7:0]  exp_strb;
    } vec_t;

    vec_t vecs[5];

    int compared = 0;
    int errors   = 0;
    int cyc      = 0;
    int n_ifu_ack = 0, n_rd_ack = 0, n_wr_ack = 0;
    int n_ifu_val = 0, n_lsu_val = 0, n_done = 0;
    int lsu_left = 0;
    int ack_log[$];
    int lsu_ack_cyc[$];
    int lsu_val_cyc[$];
    logic [63:0] lsu_val_data[$];
    logic [63:0] m_ifu_data = '0;
    logic [63:0] m_lsu_data = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (biu_ifu_rd_ack) begin n_ifu_ack++; ack_log.push_back(0); end
        if (biu_lsu_rd_ack) begin
            n_rd_ack++; ack_log.push_back(1); lsu_ack_cyc.push_back(cyc);
        end
        if (biu_lsu_wr_ack) begin n_wr_ack++; ack_log.push_back(2); end
        if (biu_ifu_data_valid) n_ifu_val++;
        if (biu_lsu_data_valid) begin
            n_lsu_val++;
            lsu_val_cyc.push_back(cyc);
            lsu_val_data.push_back(biu_lsu_data);
        end
        if (biu_lsu_write_done) n_done++;
    endtask

    // One cycle with an ideal memory: gnt on first REQ cycle, response next
    task automatic step_auto();
        logic g, w;
        logic [31:0] a;
        g = mem_biu_gnt;
        w = biu_mem_we;
        a = biu_mem_addr;
        tick();
        mem_biu_rvalid = 1'b0;
        mem_biu_bvalid = 1'b0;
        if (g) begin
            if (w) mem_biu_bvalid = 1'b1;
            else begin
                mem_biu_rvalid = 1'b1;
                mem_biu_rdata  = {32'hCAFE0000, a};
            end
        end
        mem_biu_gnt = biu_mem_req;
        if (biu_lsu_wr_ack) lsu_biu_wr_req = 1'b0;
        if (biu_ifu_rd_ack) ifu_biu_rd_req = 1'b0;
        if (biu_lsu_rd_ack) begin
            lsu_left--;
            lsu_biu_rd_req = (lsu_left > 0);
            lsu_biu_rd_addr += 32'd8;
        end
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        int bi, br, bw, bvi, bvl, bd;
        string s;
        s = $sformatf("v%0d", idx);
        bi = n_ifu_ack; br = n_rd_ack; bw = n_wr_ack;
        bvi = n_ifu_val; bvl = n_lsu_val; bd = n_done;
        lsu_biu_wr_strb = v.strb;
        lsu_biu_wr_data = v.wdata;
        case (v.kind)
            K_IFU: begin ifu_biu_rd_req = 1'b1; ifu_biu_rd_addr = v.addr; end
            K_RD:  begin lsu_biu_rd_req = 1'b1; lsu_biu_rd_addr = v.addr; end
            default: begin lsu_biu_wr_req = 1'b1; lsu_biu_wr_addr = v.addr; end
        endcase
        tick();
        case (v.kind)
            K_IFU:   chk({s, "_ack"}, 64'(biu_ifu_rd_ack), 64'd1);
            K_RD:    chk({s, "_ack"}, 64'(biu_lsu_rd_ack), 64'd1);
            default: chk({s, "_ack"}, 64'(biu_lsu_wr_ack), 64'd1);
        endcase
        ifu_biu_rd_req = 1'b0;
        lsu_biu_rd_req = 1'b0;
        lsu_biu_wr_req = 1'b0;
        for (int g = 0; g <= v.gnt_wait; g++) begin
            chk({s, "_mem_req"}, 64'(biu_mem_req), 64'd1);
            chk({s, "_mem_addr"}, 64'(biu_mem_addr), 64'(v.addr));
            chk({s, "_mem_we"}, 64'(biu_mem_we), 64'(v.exp_we));
            chk({s, "_mem_wstrb"}, 64'(biu_mem_wstrb), 64'(v.exp_strb));
            if (v.exp_we) chk({s, "_mem_wdata"}, biu_mem_wdata, v.wdata);
            mem_biu_gnt = (g == v.gnt_wait);
            tick();
        end
        mem_biu_gnt = 1'b0;
        chk({s, "_req_drop"}, 64'(biu_mem_req), 64'd0);
        repeat (v.resp_wait) tick();
        if (v.exp_we) mem_biu_bvalid = 1'b1;
        else begin
            mem_biu_rvalid = 1'b1;
            mem_biu_rdata  = v.rdata;
        end
        tick();
        mem_biu_rvalid = 1'b0;
        mem_biu_bvalid = 1'b0;
        if (v.kind == K_IFU) m_ifu_data = v.rdata;
        if (v.kind == K_RD)  m_lsu_data = v.rdata;
        chk({s, "_ifu_valid"}, 64'(biu_ifu_data_valid), 64'(v.kind == K_IFU));
        chk({s, "_lsu_valid"}, 64'(biu_lsu_data_valid), 64'(v.kind == K_RD));
        chk({s, "_wr_done"}, 64'(biu_lsu_write_done), 64'(v.kind == K_WR));
        chk({s, "_ifu_data"}, biu_ifu_data, m_ifu_data);
        chk({s, "_lsu_data"}, biu_lsu_data, m_lsu_data);
        tick();
        chk({s, "_ifu_ack_cnt"}, 64'(n_ifu_ack - bi), 64'(v.kind == K_IFU));
        chk({s, "_rd_ack_cnt"}, 64'(n_rd_ack - br), 64'(v.kind == K_RD));
        chk({s, "_wr_ack_cnt"}, 64'(n_wr_ack - bw), 64'(v.kind == K_WR));
        chk({s, "_ifu_val_cnt"}, 64'(n_ifu_val - bvi), 64'(v.kind == K_IFU));
        chk({s, "_lsu_val_cnt"}, 64'(n_lsu_val - bvl), 64'(v.kind == K_RD));
        chk({s, "_done_cnt"}, 64'(n_done - bd), 64'(v.kind == K_WR));
    endtask

    task automatic chk_reset_outs(input string s);
        chk({s, "_ctl"}, 64'({biu_ifu_rd_ack, biu_lsu_rd_ack, biu_lsu_wr_ack,
                               biu_ifu_data_valid, biu_lsu_data_valid,
                               biu_lsu_write_done, biu_mem_req, biu_mem_we,
                               biu_mem_wstrb}), 64'd0);
        chk({s, "_addr"}, 64'(biu_mem_addr), 64'd0);
        chk({s, "_wdata"}, biu_mem_wdata, 64'd0);
        chk({s, "_ifu_data"}, biu_ifu_data, 64'd0);
        chk({s, "_lsu_data"}, biu_lsu_data, 64'd0);
    endtask

    initial begin
        int exp_starve[7];
        int bvi, bvl, bd;
        logic [63:0] seen_wdata;
        logic [7:0]  seen_strb;
        logic        bad_strb;

        vecs[0] = '{K_IFU, 32'h1C000000, 64'h0, 8'h00, 0, 1,
                    64'h0123456789ABCDEF, 1'b0, 8'h00};
        vecs[1] = '{K_RD, 32'h00000104, 64'h0, 8'hFF, 2, 0,
                    64'h1122334455667788, 1'b0, 8'h00};
        vecs[2] = '{K_WR, 32'h20000008, 64'hDEADBEEF00000000, 8'hF0, 5, 0,
                    64'h0, 1'b1, 8'hF0};
        vecs[3] = '{K_IFU, 32'h1C000040, 64'h0, 8'h00, 5, 2,
                    64'hFEDCBA9876543210, 1'b0, 8'h00};
        vecs[4] = '{K_WR, 32'h00000FFF, 64'h00000000000000AB, 8'h01, 0, 3,
                    64'h0, 1'b1, 8'h01};
        exp_starve = '{1, 1, 1, 1, 0, 1, 1};

        resetn = 1'b0;
        ifu_biu_rd_req = 1'b0; ifu_biu_rd_addr = '0;
        lsu_biu_rd_req = 1'b0; lsu_biu_rd_addr = '0;
        lsu_biu_wr_req = 1'b0; lsu_biu_wr_addr = '0;
        lsu_biu_wr_data = '0;  lsu_biu_wr_strb = '0;
        mem_biu_gnt = 1'b0; mem_biu_rvalid = 1'b0;
        mem_biu_rdata = '0; mem_biu_bvalid = 1'b0;
        repeat (3) tick();
        chk_reset_outs("rst");
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

        // All three requestors in the same IDLE cycle
        ack_log.delete();
        bd = n_done; bvi = n_ifu_val;
        bad_strb = 1'b0; seen_wdata = '0; seen_strb = '0;
        lsu_left = 1;
        ifu_biu_rd_req = 1'b1; ifu_biu_rd_addr = 32'h1C000100;
        lsu_biu_rd_req = 1'b1; lsu_biu_rd_addr = 32'h00000200;
        lsu_biu_wr_req = 1'b1; lsu_biu_wr_addr = 32'h00000300;
        lsu_biu_wr_data = 64'hDEADBEEF00000000; lsu_biu_wr_strb = 8'hF0;
        for (int i = 0; i < 60 && n_ifu_val == bvi; i++) begin
            step_auto();
            if (biu_mem_req && biu_mem_we) begin
                seen_wdata = biu_mem_wdata;
                seen_strb  = biu_mem_wstrb;
            end
            if (biu_mem_req && !biu_mem_we && biu_mem_wstrb != 8'h00)
                bad_strb = 1'b1;
        end
        chk("sim_ack_cnt", 64'(ack_log.size()), 64'd3);
        if (ack_log.size() == 3) begin
            chk("sim_first", 64'(ack_log[0]), 64'd2);
            chk("sim_second", 64'(ack_log[1]), 64'd1);
            chk("sim_third", 64'(ack_log[2]), 64'd0);
        end
        chk("sim_wstrb", 64'(seen_strb), 64'hF0);
        chk("sim_wdata", seen_wdata, 64'hDEADBEEF00000000);
        chk("sim_rd_strb_zero", 64'(bad_strb), 64'd0);
        chk("sim_done_cnt", 64'(n_done - bd), 64'd1);
        chk("sim_lsu_data", biu_lsu_data, 64'hCAFE0000_00000200);
        chk("sim_ifu_data", biu_ifu_data, 64'hCAFE0000_1C000100);
        repeat (3) step_auto();

        // IFU held while LSU streams six reads
        ack_log.delete();
        lsu_left = 6;
        lsu_biu_rd_req = 1'b1; lsu_biu_rd_addr = 32'h00000100;
        ifu_biu_rd_req = 1'b1; ifu_biu_rd_addr = 32'h1C000200;
        for (int i = 0; i < 80 && ack_log.size() < 7; i++) step_auto();
        repeat (5) step_auto();
        chk("starve_ack_cnt", 64'(ack_log.size()), 64'd7);
        for (int i = 0; i < 7 && i < ack_log.size(); i++)
            chk($sformatf("starve_order%0d", i), 64'(ack_log[i]),
                64'(exp_starve[i]));
        chk("starve_ifu_data", biu_ifu_data, 64'hCAFE0000_1C000200);
        chk("starve_lsu_last", biu_lsu_data, 64'hCAFE0000_00000128);

        // Two back-to-back LSU reads
        lsu_ack_cyc.delete(); lsu_val_cyc.delete(); lsu_val_data.delete();
        lsu_left = 2;
        lsu_biu_rd_req = 1'b1; lsu_biu_rd_addr = 32'h00000100;
        for (int i = 0; i < 40 && lsu_val_cyc.size() < 2; i++) step_auto();
        repeat (2) step_auto();
        chk("b2b_val_cnt", 64'(lsu_val_cyc.size()), 64'd2);
        chk("b2b_ack_cnt", 64'(lsu_ack_cyc.size()), 64'd2);
        if (lsu_val_cyc.size() == 2 && lsu_ack_cyc.size() == 2) begin
            chk("b2b_spacing", 64'(lsu_ack_cyc[1] - lsu_val_cyc[0]), 64'd1);
            chk("b2b_data0", lsu_val_data[0], 64'hCAFE0000_00000100);
            chk("b2b_data1", lsu_val_data[1], 64'hCAFE0000_00000108);
        end

        // Reset while waiting for read data
        bvi = n_ifu_val; bvl = n_lsu_val; bd = n_done;
        ifu_biu_rd_req = 1'b1; ifu_biu_rd_addr = 32'h1C000500;
        tick();
        chk("rstw_ack", 64'(biu_ifu_rd_ack), 64'd1);
        ifu_biu_rd_req = 1'b0;
        mem_biu_gnt = 1'b1;
        tick();
        mem_biu_gnt = 1'b0;
        chk("rstw_req_drop", 64'(biu_mem_req), 64'd0);
        tick();
        resetn = 1'b0;
        tick();
        chk_reset_outs("rstw");
        resetn = 1'b1;
        mem_biu_rvalid = 1'b1; mem_biu_rdata = 64'h5555AAAA5555AAAA;
        tick();
        mem_biu_rvalid = 1'b0; mem_biu_bvalid = 1'b1;
        tick();
        mem_biu_bvalid = 1'b0;
        repeat (3) tick();
        chk("rstw_ifu_val_cnt", 64'(n_ifu_val - bvi), 64'd0);
        chk("rstw_lsu_val_cnt", 64'(n_lsu_val - bvl), 64'd0);
        chk("rstw_done_cnt", 64'(n_done - bd), 64'd0);
        chk("rstw_ifu_data", biu_ifu_data, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, errors);
        $finish;
    end

endmodule
